harmonic_extractor: RTL
=======================

// Module: harmonic_extractor
// PURPOSE
//  Producer side of the THD path. Captures one FFT magnitude frame (mag_valid/mag_index/mag_data),
//  locates the fundamental bin k1, then reads bins 2k1..5k1 from a frame buffer.
//  Presents h1..h5 with a one-cycle harm_valid strobe that drives thd_calculator's mag_valid.
//  Sits between the FFT magnitude stage and thd_calculator.
// PARAMETERS
//  FFT_N    1024  frame length (bins 0..FFT_N-1)
//  DW       32    magnitude width
//  KW       10    bin index width, clog2(FFT_N)
//  DC_SKIP  2     bins 0..DC_SKIP-1 excluded from fundamental search
//  WIN      1     harmonic search radius in bins (used only with HARM_PEAK_SEARCH_EN)
// PORTS
//  clk         in   1    system clock
//  rst_n       in   1    asynchronous active-low reset
//  mag_valid   in   1    magnitude sample valid
//  mag_index   in   KW   bin index of mag_data
//  mag_data    in   DW   magnitude of bin mag_index
//  h1..h5      out  DW   each: magnitude of harmonic n (n=1..5), held until next harm_valid
//  fund_index  out  KW   detected fundamental bin k1
//  harm_valid  out  1    one-cycle strobe: h1..h5, fund_index updated
//  busy        out  1    high outside S_WAIT0/S_CAPT (harmonic read in progress)
//  frame_drop  out  1    one-cycle pulse: frame start (index 0) rejected while busy
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0, state S_WAIT0, peak regs cleared. Reset mid-read aborts
//    with no harm_valid. Buffer contents undefined after reset.
//  - Buffer: FFT_N x DW single-clock simple dual-port RAM, 1-cycle registered read.
//  - S_WAIT0: ignore samples until mag_valid && mag_index==0; that beat is written, peak cleared,
//    go S_CAPT.
//  - S_CAPT: every mag_valid beat writes mag_data at mag_index. If DC_SKIP <= idx <= FFT_N/2-1 and
//    mag_data > peak_val (strict), update peak_val/peak_idx. Ties: lowest index wins.
//    Beat with mag_index==FFT_N-1 ends the frame -> S_READ. No in-order check on intermediate indices.
//  - S_READ: for n=2..5, target t=n*k1 (KW+3 bit product, no wrap). If t > FFT_N/2-1, h_n=0 and no
//    RAM read (still takes its R slots). Without macro R=1: read bin t.
//  - Latency: harm_valid rises exactly 4*R+2 cycles after the edge accepting the FFT_N-1 beat.
//    Result: h1=peak_val, fund_index=peak_idx.
//  - Then -> S_WAIT0; busy falls in the same cycle harm_valid is high.
//  - Zero frame (peak_val==0 at frame end): fund_index=0, h1..h5=0, harm_valid still pulses at
//    the same latency.
//  - mag_valid with index 0 while busy: sample dropped, frame_drop pulses; the rest of that frame
//    is ignored (re-arm at next index 0).
//  - Index 0 in S_CAPT: restarts capture (peak cleared), no pulse.
//  - Outputs registered; h1..h5 never change except on the harm_valid cycle.
// CONFIGURATION
//  HARM_PEAK_SEARCH_EN defined:
//   - Each harmonic reads R=2*WIN+1 bins t-WIN..t+WIN; h_n = max of those bins.
//   - Bins outside 0..FFT_N/2-1 count as 0.
//   - A fundamental leaking into neighbouring bins is tolerated.
//  HARM_PEAK_SEARCH_EN undefined:
//   - R=1, exact bin only.
//   - Search comparator and window counter not built.
// TESTING
//  1 Frame all 0 except bin 34=1000, 68=100, 102=50, 136=20, 170=10 -> 6 cycles after last beat:
//    harm_valid=1, fund_index=34, h1..h5=1000,100,50,20,10.
//  2 k1=200 (FFT_N=1024): bins 400=80, 600=70 -> h2=80, h3..h5=0 (600/800/1000 > 511).
//  3 Bins 0,1=5000 (DC), 10=300, 20=300, 30=40 -> fund_index=10 (DC skipped, tie -> lowest),
//    h2=300, h3=40.
//  4 All-zero frame -> harm_valid pulses, fund_index=0, h1..h5=0.
//  5 Second frame starts 2 cycles after first ends -> frame_drop=1 once, first results intact,
//    third frame processed normally.
//  6 rst_n low during S_READ -> no harm_valid, outputs 0, next full frame correct.
//    With HARM_PEAK_SEARCH_EN, WIN=1: bin 34=1000, 69=90, 68=0 -> h2=90, latency 14.

Source files
------------

// File: rtl/harmonic_extractor.sv
// rtl/harmonic_extractor.sv - FFT frame capture, fundamental search and harmonic bin readout
// Optional feature macro: HARM_PEAK_SEARCH_EN (each harmonic = max over bins t-WIN..t+WIN)
module harmonic_extractor #(
    parameter int FFT_N   = 1024,
    parameter int DW      = 32,
    parameter int KW      = 10,
    parameter int DC_SKIP = 2,
    parameter int WIN     = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mag_valid,
    input  logic [KW-1:0] mag_index,
    input  logic [DW-1:0] mag_data,
    output logic [DW-1:0] h1,
    output logic [DW-1:0] h2,
    output logic [DW-1:0] h3,
    output logic [DW-1:0] h4,
    output logic [DW-1:0] h5,
    output logic [KW-1:0] fund_index,
    output logic          harm_valid,
    output logic          busy,
    output logic          frame_drop
);
    localparam int HALF = FFT_N / 2;
`ifdef HARM_PEAK_SEARCH_EN
    localparam int R  = 2 * WIN + 1;
    localparam int WS = $clog2(R + 1);
`else
    // WIN only shapes the windowed build; the exact-bin build reads one bin per harmonic
    localparam int R  = 1 + 0 * WIN;
`endif

    typedef enum logic [2:0] {S_WAIT0, S_CAPT, S_READ, S_DRAIN, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] mem [FFT_N];
    logic [DW-1:0] rd_data, peak_val;
    logic [KW-1:0] peak_idx, rd_addr;
    logic [1:0]    harm, sel_q;
    logic          acc_en_q, ok_q, in_rng, wr_en, start_beat, last_slot, rd_en, zero_frame;
    logic [KW+2:0] nmul, t;
    logic [DW-1:0] hacc [4];
`ifdef HARM_PEAK_SEARCH_EN
    logic [WS-1:0] win_cnt;
    int            a_int;
`endif

    always_comb begin
        start_beat = mag_valid && (mag_index == '0);
        wr_en      = mag_valid && ((state == S_CAPT) || ((state == S_WAIT0) && (mag_index == '0)));
        busy       = !((state == S_WAIT0) || (state == S_CAPT));
        nmul       = (KW+3)'(harm) + (KW+3)'(2);
        t          = nmul * (KW+3)'(peak_idx);
`ifdef HARM_PEAK_SEARCH_EN
        a_int      = int'(t) + int'(win_cnt) - WIN;
        in_rng     = (a_int >= 0) && (a_int <= HALF - 1);
        rd_addr    = KW'(a_int);
        last_slot  = (harm == 2'd3) && (win_cnt == WS'(R - 1));
`else
        in_rng     = (t <= (KW+3)'(HALF - 1));
        rd_addr    = t[KW-1:0];
        last_slot  = (harm == 2'(4 * R - 1));
`endif
        rd_en      = (state == S_READ) && in_rng;
        zero_frame = (peak_val == '0);
        state_nxt  = state;
        case (state)
            S_WAIT0: if (start_beat) state_nxt = S_CAPT;
            S_CAPT:  if (mag_valid && (mag_index == KW'(FFT_N - 1))) state_nxt = S_READ;
            S_READ:  if (last_slot) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_WAIT0;
            default: state_nxt = S_WAIT0;
        endcase
    end

    // Frame buffer: simple dual-port, registered read, contents not reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[mag_index] <= mag_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_WAIT0;
            peak_val   <= '0;
            peak_idx   <= '0;
            harm       <= '0;
            sel_q      <= '0;
            acc_en_q   <= 1'b0;
            ok_q       <= 1'b0;
            for (int i = 0; i < 4; i++) hacc[i] <= '0;
            h1         <= '0;
            h2         <= '0;
            h3         <= '0;
            h4         <= '0;
            h5         <= '0;
            fund_index <= '0;
            harm_valid <= 1'b0;
            frame_drop <= 1'b0;
`ifdef HARM_PEAK_SEARCH_EN
            win_cnt    <= '0;
`endif
        end else begin
            state      <= state_nxt;
            harm_valid <= (state == S_DONE);
            frame_drop <= start_beat && busy;
            acc_en_q   <= (state == S_READ);
            ok_q       <= in_rng;
            sel_q      <= harm;

            if (state == S_READ) begin
`ifdef HARM_PEAK_SEARCH_EN
                if (win_cnt == WS'(R - 1)) begin
                    win_cnt <= '0;
                    harm    <= harm + 2'd1;
                end else begin
                    win_cnt <= win_cnt + 1'b1;
                end
`else
                harm <= harm + 2'd1;
`endif
            end else begin
                harm <= '0;
`ifdef HARM_PEAK_SEARCH_EN
                win_cnt <= '0;
`endif
            end

            if (!busy) begin
                for (int i = 0; i < 4; i++) hacc[i] <= '0;
            end else if (acc_en_q) begin
`ifdef HARM_PEAK_SEARCH_EN
                if (ok_q && (rd_data > hacc[sel_q])) hacc[sel_q] <= rd_data;
`else
                hacc[sel_q] <= ok_q ? rd_data : '0;
`endif
            end

            // Strict compare keeps the lowest index on ties for in-order frames
            if (wr_en && (mag_index == '0)) begin
                peak_val <= '0;
                peak_idx <= '0;
            end else if ((state == S_CAPT) && mag_valid && (mag_index >= KW'(DC_SKIP)) &&
                         (mag_index <= KW'(HALF - 1)) && (mag_data > peak_val)) begin
                peak_val <= mag_data;
                peak_idx <= mag_index;
            end

            if (state == S_DONE) begin
                h1         <= peak_val;
                fund_index <= zero_frame ? '0 : peak_idx;
                h2         <= zero_frame ? '0 : hacc[0];
                h3         <= zero_frame ? '0 : hacc[1];
                h4         <= zero_frame ? '0 : hacc[2];
                h5         <= zero_frame ? '0 : hacc[3];
            end
        end
    end
endmodule
